set_assoc_cache_ctrl: RTL

Parametrised N-way set-associative, write-back/write-allocate cache controller with internally held tag, valid, dirty and LRU-age metadata. It sits between the CPU-side request port and the cache data array / main-memory interface. It resolves hit or miss, selects a victim by true LRU, writes back dirty victims, refills, then performs the access. It also emits a one-cycle completion pulse.

---
 rtl/cache_ctrl_pkg.sv | 39 +++
 rtl/lru_victim_sel.sv | 69 ++++++
 rtl/set_assoc_cache_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cache_ctrl_pkg
// Purpose  : Shared definitions for the set-associative cache controller.
//            Holds the controller state encoding, the default geometry
//            constants and a ceil(log2) helper for derived widths.
// Revision : 1.0 - initial release
// ============================================================================
package cache_ctrl_pkg;

  localparam int C_ADDR_W   = 24;
  localparam int C_OFFSET_W = 6;
  localparam int C_INDEX_W  = 7;
  localparam int C_WAYS     = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    HIT    = 3'd2,
    EVICT  = 3'd3,
    REFILL = 3'd4,
    DONE   = 3'd5
  } state_t;

  // ceil(log2(value)); returns 0 for value <= 1
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lru_victim_sel.sv
`default_nettype none
// ============================================================================
// Module   : lru_victim_sel
// Purpose  : Combinational true-LRU helper for one cache set.
//            - o_victim   : lowest-index invalid way, otherwise the way with
//                           the largest age (lowest index wins a tie).
//            - o_age_upd  : age vector after touching way i_acc_way; ways
//                           younger than the touched way age by one and the
//                           touched way becomes 0, so ages stay a permutation.
// Ports    : i_valid   [WAYS]        valid bits of the set
//            i_age     [WAYS*WAY_W]  packed ages, way i at [i*WAY_W +: WAY_W]
//            i_acc_way [WAY_W]       way being accessed
//            o_victim  [WAY_W]       replacement candidate
//            o_age_upd [WAYS*WAY_W]  ages after accessing i_acc_way
// Revision : 1.0 - initial release
// ============================================================================
module lru_victim_sel #(
  parameter int WAYS  = 4,
  parameter int WAY_W = 2
) (
  input  logic [WAYS-1:0]       i_valid,
  input  logic [WAYS*WAY_W-1:0] i_age,
  input  logic [WAY_W-1:0]      i_acc_way,
  output logic [WAY_W-1:0]      o_victim,
  output logic [WAYS*WAY_W-1:0] o_age_upd
);

  logic             w_found_inv;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_max_way;
  logic [WAY_W-1:0] w_max_age;
  logic [WAY_W-1:0] w_acc_age;

  always_comb begin
    w_found_inv = 1'b0;
    w_inv_way   = '0;
    // Descending scan so the last hit is the lowest-index invalid way
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (!i_valid[i]) begin
        w_found_inv = 1'b1;
        w_inv_way   = WAY_W'(i);
      end
    end
    // Strict compare keeps the lowest index on equal ages
    w_max_way = '0;
    w_max_age = i_age[WAY_W-1:0];
    for (int i = 1; i < WAYS; i++) begin
      if (i_age[i*WAY_W +: WAY_W] > w_max_age) begin
        w_max_age = i_age[i*WAY_W +: WAY_W];
        w_max_way = WAY_W'(i);
      end
    end
    o_victim = w_found_inv ? w_inv_way : w_max_way;
  end

  always_comb begin
    w_acc_age = i_age[i_acc_way*WAY_W +: WAY_W];
    o_age_upd = i_age;
    for (int i = 0; i < WAYS; i++) begin
      if (WAY_W'(i) == i_acc_way) begin
        o_age_upd[i*WAY_W +: WAY_W] = '0;
      end else if (i_age[i*WAY_W +: WAY_W] < w_acc_age) begin
        o_age_upd[i*WAY_W +: WAY_W] = i_age[i*WAY_W +: WAY_W] + WAY_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/set_assoc_cache_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : set_assoc_cache_ctrl
// Purpose  : N-way set-associative write-back / write-allocate cache
//            controller. Keeps tag, valid, dirty and LRU-age metadata,
//            resolves hit/miss, writes back dirty victims, refills, then
//            issues one data-array access and a one-cycle done pulse.
// Ports    : clk, rst_b (async, active-low)
//            i_req_valid/i_req_write/i_req_addr, o_req_ready   CPU side
//            o_cache_rd/o_cache_wr/o_cache_way/o_cache_set     data array
//            o_mem_rd/o_mem_wr/o_mem_addr, i_mem_ready         memory side
//            o_done/o_resp_hit                                  completion
//            o_hit_cnt/o_miss_cnt/o_wb_cnt                      statistics
// Macro    : CACHE_CTRL_STATS_EN - enables the saturating statistics
//            counters; when undefined the counter ports are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module set_assoc_cache_ctrl
  import cache_ctrl_pkg::*;
#(
  parameter int ADDR_W   = C_ADDR_W,
  parameter int OFFSET_W = C_OFFSET_W,
  parameter int INDEX_W  = C_INDEX_W,
  parameter int WAYS     = C_WAYS
) (
  input  logic                        clk,
  input  logic                        rst_b,
  input  logic                        i_req_valid,
  input  logic                        i_req_write,
  input  logic [ADDR_W-1:0]           i_req_addr,
  output logic                        o_req_ready,
  output logic                        o_cache_rd,
  output logic                        o_cache_wr,
  output logic [clog2(WAYS)-1:0]      o_cache_way,
  output logic [INDEX_W-1:0]          o_cache_set,
  output logic                        o_mem_rd,
  output logic                        o_mem_wr,
  output logic [ADDR_W-1:0]           o_mem_addr,
  input  logic                        i_mem_ready,
  output logic                        o_done,
  output logic                        o_resp_hit,
  output logic [31:0]                 o_hit_cnt,
  output logic [31:0]                 o_miss_cnt,
  output logic [31:0]                 o_wb_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int WAY_W = clog2(WAYS);
  localparam int AGE_W = WAY_W;
  localparam int SETS  = 1 << INDEX_W;

  // Metadata storage
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS-1:0]       r_dirty [SETS];
  logic [WAYS*AGE_W-1:0] r_age   [SETS];

  // Transaction context
  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_write;
  logic                r_hit;
  logic [WAY_W-1:0]    r_way;
  logic                r_mem_rd;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;

  logic [INDEX_W-1:0]     w_idx;
  logic [TAG_W-1:0]       w_req_tag;
  logic                   w_hit;
  logic [WAY_W-1:0]       w_hit_way;
  logic [WAY_W-1:0]       w_victim;
  logic [TAG_W-1:0]       w_vic_tag;
  logic [WAYS*AGE_W-1:0]  w_age_upd;
  logic                   w_unused_offset;

  assign w_idx           = r_addr[OFFSET_W +: INDEX_W];
  assign w_req_tag       = r_addr[ADDR_W-1 -: TAG_W];
  assign w_vic_tag       = r_tag[w_idx][w_victim];
  assign w_unused_offset = ^r_addr[OFFSET_W-1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      if (!w_hit && r_valid[w_idx][i] && (r_tag[w_idx][i] == w_req_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(i);
      end
    end
  end

  // Victim is only consumed in LOOKUP; the age update only in HIT, where
  // r_way already holds the way being accessed.
  lru_victim_sel #(
    .WAYS  (WAYS),
    .WAY_W (WAY_W)
  ) u_lru (
    .i_valid   (r_valid[w_idx]),
    .i_age     (r_age[w_idx]),
    .i_acc_way (r_way),
    .o_victim  (w_victim),
    .o_age_upd (w_age_upd)
  );

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = 1'b0;
    o_cache_rd  = 1'b0;
    o_cache_wr  = 1'b0;
    o_cache_way = '0;
    o_cache_set = '0;
    o_done      = 1'b0;
    o_resp_hit  = 1'b0;
    unique case (r_state)
      IDLE: begin
        o_req_ready = 1'b1;
        if (i_req_valid) w_state_nxt = LOOKUP;
      end
      LOOKUP: begin
        if (w_hit)                                                    w_state_nxt = HIT;
        else if (r_valid[w_idx][w_victim] && r_dirty[w_idx][w_victim]) w_state_nxt = EVICT;
        else                                                           w_state_nxt = REFILL;
      end
      EVICT: begin
        if (i_mem_ready) w_state_nxt = REFILL;
      end
      REFILL: begin
        if (i_mem_ready) w_state_nxt = HIT;
      end
      HIT: begin
        o_cache_rd  = !r_write;
        o_cache_wr  = r_write;
        o_cache_way = r_way;
        o_cache_set = w_idx;
        w_state_nxt = DONE;
      end
      DONE: begin
        o_done      = 1'b1;
        o_resp_hit  = r_hit;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request context
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_hit   <= 1'b0;
      r_way   <= '0;
    end else begin
      if (r_state == IDLE && i_req_valid) begin
        r_addr  <= i_req_addr;
        r_write <= i_req_write;
      end
      if (r_state == LOOKUP) begin
        r_hit <= w_hit;
        r_way <= w_hit ? w_hit_way : w_victim;
      end
    end
  end

  // Memory strobes/address are registered off the next state so they are
  // glitch-free and constant for the whole phase.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_mem_rd   <= 1'b0;
      r_mem_wr   <= 1'b0;
      r_mem_addr <= '0;
    end else begin
      unique case (w_state_nxt)
        EVICT: begin
          r_mem_wr <= 1'b1;
          r_mem_rd <= 1'b0;
          if (r_state == LOOKUP) r_mem_addr <= {w_vic_tag, w_idx, {OFFSET_W{1'b0}}};
        end
        REFILL: begin
          r_mem_wr   <= 1'b0;
          r_mem_rd   <= 1'b1;
          r_mem_addr <= {w_req_tag, w_idx, {OFFSET_W{1'b0}}};
        end
        default: begin
          r_mem_wr   <= 1'b0;
          r_mem_rd   <= 1'b0;
          r_mem_addr <= '0;
        end
      endcase
    end
  end

  assign o_mem_rd   = r_mem_rd;
  assign o_mem_wr   = r_mem_wr;
  assign o_mem_addr = r_mem_addr;

  // --------------------------------------------------------------------------
  // Metadata
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_dirty[s] <= '0;
        for (int i = 0; i < WAYS; i++) begin
          r_age[s][i*AGE_W +: AGE_W] <= AGE_W'(i);
        end
      end
    end else begin
      if (r_state == EVICT && i_mem_ready) begin
        r_dirty[w_idx][r_way] <= 1'b0;
      end
      if (r_state == REFILL && i_mem_ready) begin
        r_valid[w_idx][r_way] <= 1'b1;
        r_dirty[w_idx][r_way] <= 1'b0;
      end
      if (r_state == HIT) begin
        r_age[w_idx] <= w_age_upd;
        if (r_write) r_dirty[w_idx][r_way] <= 1'b1;
      end
    end
  end

  // Tags are qualified by valid, so they need no reset
  always_ff @(posedge clk) begin
    if (r_state == REFILL && i_mem_ready) begin
      r_tag[w_idx][r_way] <= w_req_tag;
    end
  end

  // --------------------------------------------------------------------------
  // Statistics
  // --------------------------------------------------------------------------
`ifdef CACHE_CTRL_STATS_EN
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;
  logic [31:0] r_wb_cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
      r_wb_cnt   <= '0;
    end else begin
      if (r_state == DONE && r_hit && r_hit_cnt != 32'hFFFF_FFFF)
        r_hit_cnt <= r_hit_cnt + 32'd1;
      if (r_state == DONE && !r_hit && r_miss_cnt != 32'hFFFF_FFFF)
        r_miss_cnt <= r_miss_cnt + 32'd1;
      if (r_state == EVICT && i_mem_ready && r_wb_cnt != 32'hFFFF_FFFF)
        r_wb_cnt <= r_wb_cnt + 32'd1;
    end
  end

  assign o_hit_cnt  = r_hit_cnt;
  assign o_miss_cnt = r_miss_cnt;
  assign o_wb_cnt   = r_wb_cnt;
`else
  assign o_hit_cnt  = 32'd0;
  assign o_miss_cnt = 32'd0;
  assign o_wb_cnt   = 32'd0;
`endif

endmodule
`default_nettype wire
